pwm_ctrl_fsm: RTL and testbench
===============================

Name: pwm_ctrl_fsm

Overview:
Sequencing controller for the 16-bit PWM datapath (period/active registers, down-counter, two equality comparators).
- Accepts new period/active configurations over a valid/ready handshake and holds them in a shadow register.
- Drives loadReg/loadCNT so a new configuration takes effect only at a period boundary (glitch-free).
- Generates the registered PWM output from the datapath flags isEq0/isEq1.

Parameters:
WIDTH, 16, width of period/active values and of periodIn/activeIn.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  run enable; low forces IDLE
cfg_valid  input  1  new configuration offered
cfg_ready  output  1  shadow register empty; handshake when cfg_valid&cfg_ready
cfg_period  input  WIDTH  requested period value
cfg_active  input  WIDTH  requested active value
cfg_err  output  1  one-cycle pulse: accepted config rejected (period==0)
isEq0  input  1  datapath flag: count==0
isEq1  input  1  datapath flag: count==ACTIVE
periodIn  output  WIDTH  to datapath period register
activeIn  output  WIDTH  to datapath active register
loadReg  output  1  load datapath period/active registers
loadCNT  output  1  reload datapath counter from PERIOD
pwm_out  output  1  PWM waveform
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE; pwm_out, loadReg, loadCNT, cfg_err, busy = 0; cfg_ready=1.
  - Shadow registers, periodIn and activeIn = 0; flags pending=0, has_cfg=0.
- Handshake:
  - Transfer occurs on the clk edge where cfg_valid=1 and cfg_ready=1; cfg_ready = !pending.
  - If cfg_period==0: the transfer completes but the config is discarded; cfg_err pulses the next cycle; pending is unchanged.
  - Otherwise the shadow stores period and clamps active to min(cfg_active, cfg_period); pending=1.
- periodIn/activeIn are registered copies of the shadow and change only in LOAD_REG.
- States:
  - IDLE:
    - en & pending goes to LOAD_REG.
    - en & !pending & has_cfg goes to LOAD_CNT.
    - Otherwise stay.
  - LOAD_REG:
    - loadReg=1 for exactly one cycle; periodIn/activeIn hold the shadow values; pending cleared; has_cfg set.
    - Next state is LOAD_CNT.
  - LOAD_CNT: loadCNT=1 for exactly one cycle; next state is RUN.
  - RUN:
    - isEq1 sets pwm_out at the next edge.
    - isEq0 clears pwm_out at the next edge and leaves RUN: to LOAD_REG if pending, else to LOAD_CNT.
- isEq0/isEq1 are ignored outside RUN. pwm_out is forced 0 in IDLE, LOAD_REG and LOAD_CNT.
- loadReg and loadCNT are registered outputs and are never high in the same cycle.
- Simultaneous isEq0 & isEq1 in RUN (ACTIVE==0): clear wins, giving 0% duty.
- Timing, with a counter decrementing by 1 per clk:
  - Output period = PERIOD+2 clk (PERIOD+1 RUN cycles plus 1 LOAD_CNT cycle).
  - pwm_out high for ACTIVE clk per period.
  - ACTIVE==PERIOD gives pwm_out high from the second RUN cycle to the end of RUN.
- en deasserted in any state: next state is IDLE and pwm_out=0 at the next edge. A pending config is kept.
- A config accepted during RUN is applied only at the next isEq0. At most one config is pending; further offers stall (cfg_ready=0).
- An async reset mid-period returns all outputs to reset values immediately. has_cfg is lost, so a new config is required.

Optional Feature:
PWM_PERIOD_IRQ_EN:
- Defined: adds output period_irq (1 bit). It pulses high for one cycle on the edge after isEq0 is seen in RUN, i.e. concurrent with LOAD_REG/LOAD_CNT entry. It also pulses in the cycle LOAD_REG applies a new config, even if no period ended there.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then cfg period=10, active=4, en=1 -> loadReg pulse, then loadCNT pulse next cycle; pwm_out period 12 clk, high 4 clk, repeating.
- Mid-RUN cfg period=6, active=3 -> old waveform completes its current period; loadReg pulses at the boundary; subsequent periods 8 clk / 3 high. A second offer while pending sees cfg_ready=0.
- cfg period=0 -> cfg_err one-cycle pulse; pending stays 0; running waveform unchanged.
- cfg period=5, active=9 -> active clamped to 5 (activeIn=5); active=0 -> pwm_out constantly 0 while busy=1.
- en dropped mid-high phase -> pwm_out=0 next edge, state IDLE, busy=0. en re-raised -> LOAD_CNT directly with no loadReg; same waveform resumes.
- Async reset asserted mid-RUN, off-edge -> pwm_out/loadCNT/busy=0 immediately; en=1 with no new cfg keeps IDLE. With PWM_PERIOD_IRQ_EN defined, period_irq pulses once per period.

Source files
------------

// File: rtl/pwm_ctrl_fsm.sv
// Sequencing controller for a 16-bit PWM datapath: config handshake, shadow
// register, boundary-aligned loads and registered PWM output. Optional macro: PWM_PERIOD_IRQ_EN.
module pwm_ctrl_fsm #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_active,
    output logic             cfg_err,
    input  logic             isEq0,
    input  logic             isEq1,
    output logic [WIDTH-1:0] periodIn,
    output logic [WIDTH-1:0] activeIn,
    output logic             loadReg,
    output logic             loadCNT,
    output logic             pwm_out,
    output logic             busy
`ifdef PWM_PERIOD_IRQ_EN
    ,
    output logic             period_irq
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_REG = 2'd1,
        LOAD_CNT = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic             pending_q, pending_d;
    logic             has_cfg_q, has_cfg_d;
    logic [WIDTH-1:0] shadow_period_q, shadow_period_d;
    logic [WIDTH-1:0] shadow_active_q, shadow_active_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             cfg_err_q, cfg_err_d;
    logic             load_reg_q, load_reg_d;
    logic             load_cnt_q, load_cnt_d;
    logic             pwm_q, pwm_d;
    logic             busy_q, busy_d;
    logic             cfg_accept;
`ifdef PWM_PERIOD_IRQ_EN
    logic             irq_q, irq_d;
`endif

    // The active phase can never be longer than the period itself.
    function automatic logic [WIDTH-1:0] clamp_active(input logic [WIDTH-1:0] act,
                                                      input logic [WIDTH-1:0] per);
        return (act > per) ? per : act;
    endfunction

    assign cfg_ready  = !pending_q;
    assign cfg_accept = cfg_valid && !pending_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_d = LOAD_REG;
                    end else if (has_cfg_q) begin
                        state_d = LOAD_CNT;
                    end
                end
                LOAD_REG: state_d = LOAD_CNT;
                LOAD_CNT: state_d = RUN;
                RUN: begin
                    if (isEq0) begin
                        state_d = pending_q ? LOAD_REG : LOAD_CNT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Shadow capture and boundary transfer; entering LOAD_REG needs pending,
    // which blocks the handshake, so the two branches never coincide.
    always_comb begin
        pending_d       = pending_q;
        has_cfg_d       = has_cfg_q;
        shadow_period_d = shadow_period_q;
        shadow_active_d = shadow_active_q;
        period_d        = period_q;
        active_d        = active_q;
        cfg_err_d       = cfg_accept && (cfg_period == '0);
        if (state_d == LOAD_REG) begin
            period_d  = shadow_period_q;
            active_d  = shadow_active_q;
            pending_d = 1'b0;
            has_cfg_d = 1'b1;
        end else if (cfg_accept && (cfg_period != '0)) begin
            shadow_period_d = cfg_period;
            shadow_active_d = clamp_active(cfg_active, cfg_period);
            pending_d       = 1'b1;
        end
    end

    always_comb begin
        load_reg_d = (state_d == LOAD_REG);
        load_cnt_d = (state_d == LOAD_CNT);
        busy_d     = (state_d != IDLE);
        // Leaving RUN (isEq0 or en low) forces 0, so clear wins over set.
        pwm_d      = 1'b0;
        if ((state_q == RUN) && (state_d == RUN)) begin
            pwm_d = isEq1 | pwm_q;
        end
`ifdef PWM_PERIOD_IRQ_EN
        irq_d = (state_d == LOAD_REG) ||
                ((state_q == RUN) && isEq0 && (state_d != IDLE));
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q       <= 1'b0;
            has_cfg_q       <= 1'b0;
            shadow_period_q <= '0;
            shadow_active_q <= '0;
            period_q        <= '0;
            active_q        <= '0;
            cfg_err_q       <= 1'b0;
            load_reg_q      <= 1'b0;
            load_cnt_q      <= 1'b0;
            pwm_q           <= 1'b0;
            busy_q          <= 1'b0;
`ifdef PWM_PERIOD_IRQ_EN
            irq_q           <= 1'b0;
`endif
        end else begin
            pending_q       <= pending_d;
            has_cfg_q       <= has_cfg_d;
            shadow_period_q <= shadow_period_d;
            shadow_active_q <= shadow_active_d;
            period_q        <= period_d;
            active_q        <= active_d;
            cfg_err_q       <= cfg_err_d;
            load_reg_q      <= load_reg_d;
            load_cnt_q      <= load_cnt_d;
            pwm_q           <= pwm_d;
            busy_q          <= busy_d;
`ifdef PWM_PERIOD_IRQ_EN
            irq_q           <= irq_d;
`endif
        end
    end

    assign periodIn = period_q;
    assign activeIn = active_q;
    assign cfg_err  = cfg_err_q;
    assign loadReg  = load_reg_q;
    assign loadCNT  = load_cnt_q;
    assign pwm_out  = pwm_q;
    assign busy     = busy_q;
`ifdef PWM_PERIOD_IRQ_EN
    assign period_irq = irq_q;
`endif

    a_no_load_overlap: assert property (@(posedge clk) disable iff (!reset)
        !(load_reg_q && load_cnt_q));

endmodule

// File: tb/tb_pwm_ctrl_fsm.sv
// Bench for pwm_ctrl_fsm: a counter datapath closes the loop, and a
// period-position reference model predicts every output each cycle.
module tb_pwm_ctrl_fsm;

    logic        clk;
    logic        reset;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [15:0] cfg_active;
    logic        cfg_err;
    logic        isEq0;
    logic        isEq1;
    logic [15:0] periodIn;
    logic [15:0] activeIn;
    logic        loadReg;
    logic        loadCNT;
    logic        pwm_out;
    logic        busy;
    logic        dut_irq;

    int checks = 0;
    int errors = 0;

`ifdef PWM_PERIOD_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    pwm_ctrl_fsm #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_active(cfg_active), .cfg_err(cfg_err),
        .isEq0(isEq0), .isEq1(isEq1),
        .periodIn(periodIn), .activeIn(activeIn),
        .loadReg(loadReg), .loadCNT(loadCNT), .pwm_out(pwm_out), .busy(busy)
`ifdef PWM_PERIOD_IRQ_EN
        , .period_irq(dut_irq)
`endif
    );
`ifndef PWM_PERIOD_IRQ_EN
    assign dut_irq = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: registers loaded on loadReg, down-counter reloaded on loadCNT.
    logic [15:0] dp_p, dp_a, dp_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_p <= 16'd0; dp_a <= 16'd0; dp_cnt <= 16'd0;
        end else begin
            if (loadReg) begin
                dp_p <= periodIn;
                dp_a <= activeIn;
            end
            if (loadCNT) dp_cnt <= dp_p;
            else         dp_cnt <= dp_cnt - 16'd1;
        end
    end
    assign isEq0 = (dp_cnt == 16'd0);
    assign isEq1 = (dp_cnt == dp_a);

    // Reference: phase 0 idle, 1 applying config, 2 counter reload, 3 running
    // with position k in 0..P; the output is high for the last A positions.
    int m_ph, m_nph, m_k, m_nk, m_p, m_a, m_sp, m_sa;
    bit m_pend, m_has, m_err, m_irq;
    logic exp_pwm;
    logic [6:0] exp_vec, obs_vec;

    always_comb begin
        m_nph = m_ph;
        m_nk  = m_k;
        if (!en) begin
            m_nph = 0;
        end else if (m_ph == 0) begin
            if (m_pend) m_nph = 1;
            else if (m_has) m_nph = 2;
        end else if (m_ph == 1) begin
            m_nph = 2;
        end else if (m_ph == 2) begin
            m_nph = 3;
            m_nk  = 0;
        end else if (m_k >= m_p) begin
            m_nph = m_pend ? 1 : 2;
        end else begin
            m_nk = m_k + 1;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph <= 0; m_k <= 0; m_p <= 0; m_a <= 0; m_sp <= 0; m_sa <= 0;
            m_pend <= 1'b0; m_has <= 1'b0; m_err <= 1'b0; m_irq <= 1'b0;
        end else begin
            m_ph  <= m_nph;
            m_k   <= m_nk;
            m_err <= cfg_valid && !m_pend && (cfg_period == 16'd0);
            m_irq <= (m_nph == 1) || ((m_ph == 3) && (m_k >= m_p) && (m_nph != 0));
            if (m_nph == 1) begin
                m_p <= m_sp; m_a <= m_sa; m_pend <= 1'b0; m_has <= 1'b1;
            end else if (cfg_valid && !m_pend && (cfg_period != 16'd0)) begin
                m_sp   <= int'(cfg_period);
                m_sa   <= (cfg_active > cfg_period) ? int'(cfg_period) : int'(cfg_active);
                m_pend <= 1'b1;
            end
        end
    end

    assign exp_pwm = (m_ph == 3) && (m_k + m_a >= m_p + 1);
    assign exp_vec = {!m_pend, m_err, m_ph == 1, m_ph == 2, exp_pwm, m_ph != 0,
                      IRQ_EN ? m_irq : 1'b0};
    assign obs_vec = {cfg_ready, cfg_err, loadReg, loadCNT, pwm_out, busy, dut_irq};

    task automatic drive_offer(input logic [15:0] p, input logic [15:0] a, output bit ok);
        cfg_period = p;
        cfg_active = a;
        cfg_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cfg_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_active = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_vec !== 7'b1000000 || periodIn !== 16'd0 || activeIn !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: got %b p=%0d a=%0d want 1000000 p=0 a=0",
                     obs_vec, periodIn, activeIn);
        end
        reset = 1'b1; en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || loadCNT !== 1'b0 || loadReg !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_cfg_idle: got busy=%b ld=%b%b want 0 00",
                         busy, loadReg, loadCNT);
            end
        end
    endtask

    task automatic test_basic();
        bit ok, found;
        int highs, lc;
        drive_offer(16'd10, 16'd4, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_offer: accepted=0 want 1"); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            checks++;
            if ({obs_vec, periodIn, activeIn} !== {exp_vec, 16'(m_p), 16'(m_a)}) begin
                errors++;
                $display("FAIL basic_start: got %b p=%0d a=%0d want %b p=%0d a=%0d",
                         obs_vec, periodIn, activeIn, exp_vec, m_p, m_a);
            end
            if (loadCNT === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL basic_loadcnt_seen: seen=0 want 1"); end
        highs = 0; lc = 0;
        for (int i = 0; i < 36; i++) begin
            if (pwm_out === 1'b1) highs++;
            if (loadCNT === 1'b1) lc++;
            @(negedge clk);
            checks++;
            if ({obs_vec, periodIn, activeIn} !== {exp_vec, 16'(m_p), 16'(m_a)}) begin
                errors++;
                $display("FAIL basic_run: got %b p=%0d a=%0d want %b p=%0d a=%0d",
                         obs_vec, periodIn, activeIn, exp_vec, m_p, m_a);
            end
        end
        checks++;
        if (highs != 12 || lc != 3 || periodIn !== 16'd10 || activeIn !== 16'd4) begin
            errors++;
            $display("FAIL basic_waveform: got highs=%0d reloads=%0d p=%0d a=%0d want 12 3 10 4",
                     highs, lc, periodIn, activeIn);
        end
    endtask

    task automatic test_midrun_cfg();
        bit ok, found;
        int highs, lc;
        drive_offer(16'd6, 16'd3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrun_offer: accepted=0 want 1"); end
        cfg_period = 16'd7; cfg_active = 16'd2; cfg_valid = 1'b1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrun_stall: cfg_ready=%b want 0", cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            checks++;
            if ({obs_vec, periodIn, activeIn} !== {exp_vec, 16'(m_p), 16'(m_a)}) begin
                errors++;
                $display("FAIL midrun_boundary: got %b p=%0d a=%0d want %b p=%0d a=%0d",
                         obs_vec, periodIn, activeIn, exp_vec, m_p, m_a);
            end
            if (loadCNT === 1'b1 && m_p == 6) found = 1'b1;
        end
        checks++;
        if (!found || periodIn !== 16'd6 || activeIn !== 16'd3) begin
            errors++;
            $display("FAIL midrun_applied: seen=%0d p=%0d a=%0d want 1 6 3",
                     found, periodIn, activeIn);
        end
        highs = 0; lc = 0;
        for (int i = 0; i < 16; i++) begin
            if (pwm_out === 1'b1) highs++;
            if (loadCNT === 1'b1) lc++;
            @(negedge clk);
        end
        checks++;
        if (highs != 6 || lc != 2) begin
            errors++;
            $display("FAIL midrun_waveform: got highs=%0d reloads=%0d want 6 2", highs, lc);
        end
    endtask

    task automatic test_cfg_err();
        bit ok;
        drive_offer(16'd0, 16'd5, ok);
        checks++;
        if (!ok || cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_pulse: got ok=%0d err=%b ready=%b want 1 1 1",
                     ok, cfg_err, cfg_ready);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({obs_vec, periodIn, activeIn} !== {exp_vec, 16'(m_p), 16'(m_a)}) begin
                errors++;
                $display("FAIL cfg_err_run: got %b p=%0d a=%0d want %b p=%0d a=%0d",
                         obs_vec, periodIn, activeIn, exp_vec, m_p, m_a);
            end
        end
        checks++;
        if (cfg_err !== 1'b0 || periodIn !== 16'd6 || activeIn !== 16'd3) begin
            errors++;
            $display("FAIL cfg_err_unchanged: got err=%b p=%0d a=%0d want 0 6 3",
                     cfg_err, periodIn, activeIn);
        end
    endtask

    task automatic test_clamp_zero();
        bit ok, found;
        int bad;
        for (int pass = 0; pass < 2; pass++) begin
            drive_offer(16'd5, (pass == 0) ? 16'd9 : 16'd0, ok);
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                checks++;
                if ({obs_vec, periodIn, activeIn} !== {exp_vec, 16'(m_p), 16'(m_a)}) begin
                    errors++;
                    $display("FAIL clamp_cycle: got %b p=%0d a=%0d want %b p=%0d a=%0d",
                             obs_vec, periodIn, activeIn, exp_vec, m_p, m_a);
                end
                if (loadReg === 1'b1) found = 1'b1;
            end
            checks++;
            if (!ok || !found || periodIn !== 16'd5 ||
                activeIn !== ((pass == 0) ? 16'd5 : 16'd0)) begin
                errors++;
                $display("FAIL clamp_applied: got ok=%0d seen=%0d p=%0d a=%0d want 1 1 5 %0d",
                         ok, found, periodIn, activeIn, (pass == 0) ? 5 : 0);
            end
        end
        bad = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            if (pwm_out !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_duty: got %0d cycles with pwm!=0 or busy!=1 want 0", bad);
        end
    endtask

    task automatic test_en_drop();
        bit ok, found;
        int highs, lr, lc;
        drive_offer(16'd10, 16'd4, ok);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) found = 1'b1;
        end
        checks++;
        if (!ok || !found) begin
            errors++;
            $display("FAIL en_high_phase: got ok=%0d high=%0d want 1 1", ok, found);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({pwm_out, busy, loadReg, loadCNT} !== 4'b0000) begin
            errors++;
            $display("FAIL en_drop: got pwm/busy/ld=%b want 0000",
                     {pwm_out, busy, loadReg, loadCNT});
        end
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        checks++;
        if ({loadReg, loadCNT} !== 2'b01) begin
            errors++;
            $display("FAIL en_resume: got loadReg/loadCNT=%b want 01", {loadReg, loadCNT});
        end
        highs = 0; lr = 0; lc = 0;
        for (int i = 0; i < 36; i++) begin
            if (pwm_out === 1'b1) highs++;
            if (loadReg === 1'b1) lr++;
            if (loadCNT === 1'b1) lc++;
            @(negedge clk);
        end
        checks++;
        if (highs != 12 || lr != 0 || lc != 3) begin
            errors++;
            $display("FAIL en_resumed_wave: got highs=%0d loadregs=%0d reloads=%0d want 12 0 3",
                     highs, lr, lc);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) found = 1'b1;
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (!found || obs_vec !== 7'b1000000 || periodIn !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: got high=%0d %b p=%0d want 1 1000000 p=0",
                     found, obs_vec, periodIn);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_stays_idle: got %b want %b (busy 0)", obs_vec, exp_vec);
            end
        end
    endtask

`ifdef PWM_PERIOD_IRQ_EN
    task automatic test_irq();
        bit ok, found;
        int irqs, lc;
        drive_offer(16'd4, 16'd2, ok);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (loadReg === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        irqs = 0; lc = 0;
        for (int i = 0; i < 30; i++) begin
            if (dut_irq === 1'b1) irqs++;
            if (loadCNT === 1'b1) lc++;
            @(negedge clk);
        end
        checks++;
        if (!ok || !found || irqs != 5 || lc != 5) begin
            errors++;
            $display("FAIL irq_count: got ok=%0d seen=%0d irqs=%0d reloads=%0d want 1 1 5 5",
                     ok, found, irqs, lc);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            checks++;
            if ({obs_vec, periodIn, activeIn} !== {exp_vec, 16'(m_p), 16'(m_a)}) begin
                errors++;
                $display("FAIL random_cycle %0d: got %b p=%0d a=%0d want %b p=%0d a=%0d",
                         i, obs_vec, periodIn, activeIn, exp_vec, m_p, m_a);
            end
            reset      = ($urandom_range(0, 299) != 0);
            en         = ($urandom_range(0, 15) != 0);
            cfg_valid  = ($urandom_range(0, 7) == 0);
            cfg_period = 16'($urandom_range(0, 12));
            cfg_active = 16'($urandom_range(0, 15));
        end
        reset = 1'b1; cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midrun_cfg();
        test_cfg_err();
        test_clamp_zero();
        test_en_drop();
        test_async_reset();
`ifdef PWM_PERIOD_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
